// File: rtl/count_monitor_pkg.sv
// Shared types and default parameters for the count direction monitor.
// Contents: FSM state enum, delta-class enum, default parameter constants,
// and the width of the stall run counter (wide enough for any legal limit).
package count_monitor_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACQ,
    ST_UP,
    ST_DOWN
  } state_e;

  typedef enum logic [1:0] {
    DC_ZERO,
    DC_PLUS,
    DC_MINUS,
    DC_JUMP
  } dclass_e;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_REV_W       = 8;
  localparam int DEF_STALL_LIMIT = 4;

  // Stall limits range 1..255, so an 8-bit run counter always suffices.
  localparam int RUN_W = 8;

endpackage

// File: rtl/count_step_classify.sv
// Classifies the step between the previous and current count values.
// Ports: prev_i / count_i (observed values), class_o (ZERO/PLUS/MINUS/JUMP),
//        wrap_o (PLUS from max to 0, or MINUS from 0 to max). Purely combinational.
module count_step_classify
  import count_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output dclass_e          class_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] delta;
  dclass_e          cls;

  always_comb begin
    // Modulo-2^WIDTH difference; the subtraction wraps naturally.
    delta = count_i - prev_i;
    cls   = DC_JUMP;
    if (delta == '0) begin
      cls = DC_ZERO;
    end else if (delta == WIDTH'(1)) begin
      cls = DC_PLUS;
    end else if (delta == '1) begin
      cls = DC_MINUS;
    end
    class_o = cls;
    wrap_o  = ((cls == DC_PLUS)  && (prev_i == '1) && (count_i == '0)) ||
              ((cls == DC_MINUS) && (prev_i == '0) && (count_i == '1));
  end

endmodule

// File: rtl/count_direction_monitor.sv
// Passive monitor that infers up/down direction from a sampled counter value.
// Ports: clk/reset (sync, active-high), count_in + sample qualifier in;
//        dir, locked, step_up/step_down/wrap/step_err pulses, stalled level,
//        rev_count (saturating reversals) out. All outputs registered, 1-cycle latency.
module count_direction_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int REV_W       = DEF_REV_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             sample,
  output logic             dir,
  output logic             locked,
  output logic             step_up,
  output logic             step_down,
  output logic             wrap,
  output logic             step_err,
  output logic             stalled,
  output logic [REV_W-1:0] rev_count
);

  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_LIMIT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [REV_W-1:0] rev_q, rev_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             stalled_q, stalled_d;

  dclass_e          cls;
  logic             wrap_c;

  count_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev_i  (prev_q),
    .count_i (count_in),
    .class_o (cls),
    .wrap_o  (wrap_c)
  );

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    rev_d   = rev_q;
    dir_d   = dir_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;

    if (sample) begin
      prev_d = count_in;
      unique case (state_q)
        // First sample only seeds prev; there is no reference to compare against.
        ST_INIT: state_d = ST_ACQ;

        ST_ACQ: begin
          unique case (cls)
            DC_PLUS: begin
              state_d = ST_UP;
              dir_d   = 1'b1;
              up_d    = 1'b1;
              wrap_d  = wrap_c;
            end
            DC_MINUS: begin
              state_d = ST_DOWN;
              dir_d   = 1'b0;
              down_d  = 1'b1;
              wrap_d  = wrap_c;
            end
            DC_JUMP: err_d = 1'b1;
            default: ;
          endcase
        end

        ST_UP, ST_DOWN: begin
          unique case (cls)
            DC_PLUS: begin
              if ((state_q == ST_DOWN) && (rev_q != '1)) rev_d = rev_q + REV_W'(1);
              state_d = ST_UP;
              dir_d   = 1'b1;
              up_d    = 1'b1;
              wrap_d  = wrap_c;
              run_d   = '0;
            end
            DC_MINUS: begin
              if ((state_q == ST_UP) && (rev_q != '1)) rev_d = rev_q + REV_W'(1);
              state_d = ST_DOWN;
              dir_d   = 1'b0;
              down_d  = 1'b1;
              wrap_d  = wrap_c;
              run_d   = '0;
            end
            DC_ZERO: begin
              if (run_q != RUN_LIMIT) run_d = run_q + RUN_W'(1);
            end
            default: begin
              // Any jump drops lock; the run is cleared as we leave UP/DOWN.
              err_d   = 1'b1;
              state_d = ST_ACQ;
              run_d   = '0;
            end
          endcase
        end

        default: state_d = ST_INIT;
      endcase
    end

    // Levels are computed from next state so they line up with the pulses.
    locked_d  = (state_d == ST_UP) || (state_d == ST_DOWN);
    stalled_d = locked_d && (run_d == RUN_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      prev_q    <= '0;
      run_q     <= '0;
      rev_q     <= '0;
      dir_q     <= 1'b0;
      locked_q  <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      rev_q     <= rev_d;
      dir_q     <= dir_d;
      locked_q  <= locked_d;
      up_q      <= up_d;
      down_q    <= down_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
      stalled_q <= stalled_d;
    end
  end

  assign dir       = dir_q;
  assign locked    = locked_q;
  assign step_up   = up_q;
  assign step_down = down_q;
  assign wrap      = wrap_q;
  assign step_err  = err_q;
  assign stalled   = stalled_q;
  assign rev_count = rev_q;

endmodule

// File: tb/tb_count_direction_monitor.sv
// Bench for count_direction_monitor: two instances (REV_W=8 and REV_W=2) share
// stimulus; directed scenarios then random samples are checked every cycle
// against an arithmetic reference model of the monitor's rules.
module tb_count_direction_monitor;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample;
  logic [3:0] count_in;

  logic       a_dir, a_locked, a_up, a_down, a_wrap, a_err, a_stalled;
  logic [7:0] a_rev;
  logic       b_dir, b_locked, b_up, b_down, b_wrap, b_err, b_stalled;
  logic [1:0] b_rev;

  always #5 clk = ~clk;

  count_direction_monitor #(.WIDTH(4), .REV_W(8), .STALL_LIMIT(LIMIT)) dut_a (
    .clk(clk), .reset(reset), .count_in(count_in), .sample(sample),
    .dir(a_dir), .locked(a_locked), .step_up(a_up), .step_down(a_down),
    .wrap(a_wrap), .step_err(a_err), .stalled(a_stalled), .rev_count(a_rev)
  );

  count_direction_monitor #(.WIDTH(4), .REV_W(2), .STALL_LIMIT(LIMIT)) dut_b (
    .clk(clk), .reset(reset), .count_in(count_in), .sample(sample),
    .dir(b_dir), .locked(b_locked), .step_up(b_up), .step_down(b_down),
    .wrap(b_wrap), .step_err(b_err), .stalled(b_stalled), .rev_count(b_rev)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_have, m_locked, m_dir, m_up, m_dn, m_wrap, m_err;
  int m_prev, m_run, m_rev_a, m_rev_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic bump_rev();
    if (m_rev_a < 255) m_rev_a++;
    if (m_rev_b < 3)   m_rev_b++;
  endtask

  task automatic model_update(input bit r, input bit s, input int c);
    int d;
    m_up = 0; m_dn = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      m_have = 0; m_prev = 0; m_locked = 0; m_dir = 0;
      m_run = 0; m_rev_a = 0; m_rev_b = 0;
      return;
    end
    if (!s) return;
    if (!m_have) begin
      m_have = 1;
      m_prev = c;
      return;
    end
    d = (c - m_prev + 16) % 16;
    if (d == 1) begin
      m_up = 1; m_wrap = (m_prev == 15);
      if (m_locked && !m_dir) bump_rev();
      m_locked = 1; m_dir = 1; m_run = 0;
    end else if (d == 15) begin
      m_dn = 1; m_wrap = (m_prev == 0);
      if (m_locked && m_dir) bump_rev();
      m_locked = 1; m_dir = 0; m_run = 0;
    end else if (d == 0) begin
      if (m_locked && m_run < LIMIT) m_run++;
    end else begin
      m_err = 1; m_locked = 0; m_run = 0;
    end
    m_prev = c;
  endtask

  task automatic compare_all(input string tag);
    bit exp_stall;
    exp_stall = m_locked && (m_run == LIMIT);
    check({tag, ".a.dir"},       a_dir,     m_dir);
    check({tag, ".a.locked"},    a_locked,  m_locked);
    check({tag, ".a.step_up"},   a_up,      m_up);
    check({tag, ".a.step_down"}, a_down,    m_dn);
    check({tag, ".a.wrap"},      a_wrap,    m_wrap);
    check({tag, ".a.step_err"},  a_err,     m_err);
    check({tag, ".a.stalled"},   a_stalled, exp_stall);
    check({tag, ".a.rev"},       a_rev,     m_rev_a);
    check({tag, ".b.locked"},    b_locked,  m_locked);
    check({tag, ".b.step_up"},   b_up,      m_up);
    check({tag, ".b.step_down"}, b_down,    m_dn);
    check({tag, ".b.wrap"},      b_wrap,    m_wrap);
    check({tag, ".b.step_err"},  b_err,     m_err);
    check({tag, ".b.stalled"},   b_stalled, exp_stall);
    check({tag, ".b.dir"},       b_dir,     m_dir);
    check({tag, ".b.rev"},       b_rev,     m_rev_b);
  endtask

  // Drive one cycle, let the edge happen, update the model, check 1 time unit later.
  task automatic cyc(input string tag, input bit r, input bit s, input int c);
    reset    = r;
    sample   = s;
    count_in = 4'(c);
    @(posedge clk);
    model_update(r, s, c);
    #1;
    compare_all(tag);
  endtask

  task automatic samp(input string tag, input int c);
    cyc(tag, 1'b0, 1'b1, c);
  endtask

  initial begin
    logic [3:0] last;
    int         pick;
    bit         r, s;

    reset = 1'b1; sample = 1'b0; count_in = '0;
    cyc("reset", 1'b1, 1'b0, 0);
    cyc("reset2", 1'b1, 1'b1, 9);
    check("reset.locked", a_locked, 0);
    check("reset.rev", a_rev, 0);

    // Reset then climb
    samp("climb0", 0);
    check("climb.first_no_pulse", {a_up, a_down, a_err, a_wrap}, 0);
    samp("climb1", 1);
    samp("climb2", 2);
    samp("climb3", 3);
    check("climb.step_up", a_up, 1);
    check("climb.locked", a_locked, 1);
    check("climb.dir", a_dir, 1);

    // Up wrap (3 -> 14 is a jump first)
    samp("wrap14", 14);
    samp("wrap15", 15);
    samp("wrap0", 0);
    check("wrap.flag", a_wrap, 1);
    check("wrap.step_up", a_up, 1);
    samp("wrap1", 1);
    check("wrap.only_once", a_wrap, 0);

    // Reversal
    samp("rev4", 4);
    samp("rev5", 5);
    samp("rev6", 6);
    samp("rev5b", 5);
    check("rev.first", a_rev, 1);
    check("rev.dir_down", a_dir, 0);
    samp("rev4b", 4);
    samp("rev5c", 5);
    check("rev.second", a_rev, 2);
    check("rev.dir_up", a_dir, 1);

    // Jump / counter reset
    samp("jmp2", 2);
    samp("jmp3", 3);
    samp("jmp0", 0);
    check("jump.err", a_err, 1);
    check("jump.unlocked", a_locked, 0);
    samp("jmp1", 1);
    check("jump.relock", a_locked, 1);

    // Stall with gaps
    samp("stl6", 6);
    samp("stl7", 7);
    for (int i = 0; i < 4; i++) begin
      samp("stl_rep", 7);
      cyc("stl_gap", 1'b0, 1'b0, 12);
    end
    check("stall.set", a_stalled, 1);
    samp("stl8", 8);
    check("stall.clear", a_stalled, 0);

    // Mid-run reset while locked DOWN
    samp("dn7", 7);
    samp("dn6", 6);
    cyc("midreset", 1'b1, 1'b1, 5);
    check("midreset.all", {a_dir, a_locked, a_up, a_down, a_wrap, a_err, a_stalled, a_rev}, 0);

    // Five reversals: narrow counter saturates at 3
    samp("sat5", 5);
    samp("sat6", 6);
    for (int i = 0; i < 5; i++) begin
      samp("sat_rev", (i % 2 == 0) ? 5 : 6);
    end
    check("sat.narrow", b_rev, 3);
    check("sat.wide", a_rev, 5);

    // Random phase
    last = 4'd6;
    for (int n = 0; n < 3000; n++) begin
      r    = ($urandom_range(0, 99) == 0);
      s    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 4)      last = last + 4'd1;
      else if (pick < 7) last = last - 4'd1;
      else if (pick < 9) last = last;
      else               last = 4'($urandom_range(0, 15));
      cyc("rand", r, s, int'(last));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
